mcy_mutant_scheduler: RTL

- Sequencer for the mutation-coverage miter. It steps the shared `mutsel` select through mutants 1..N, one at a time.
- For each mutant it resets both cores, enables fetch, and runs a fixed observation window. A mismatch pulse from the miter's output comparators during the window marks the mutant killed.
- It streams one result record per mutant to a collector over a valid/ready handshake.
- It sits between the testbench control/collector and the miter's `mutsel`, `rst_ni` and `fetch_enable_i` inputs.

---
 rtl/mcy_sched_pkg.sv | 16 +
 rtl/mcy_sched_timer.sv | 30 +++
 rtl/mcy_mutant_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mcy_sched_pkg.sv
// Shared types and constants for the mutation-coverage scheduler.
package mcy_sched_pkg;

  localparam int RST_CYCLES_MIN = 1;
  localparam int SCHED_MUTSEL_W = 8;
  localparam int SCHED_CYC_W    = 16;

  typedef enum logic [2:0] {IDLE, CRST, RUN, REPORT, NEXT} sched_state_e;

  typedef struct packed {
    logic [SCHED_MUTSEL_W-1:0] mutsel;
    logic                      killed;
    logic [SCHED_CYC_W-1:0]    cycle;
  } sched_result_t;

endpackage

// File: rtl/mcy_sched_timer.sv
// Saturating up-counter with clear/enable and a terminal-count compare,
// shared by the core-reset and observation-window phases.
module mcy_sched_timer #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CYC_W-1:0] load,
  output logic [CYC_W-1:0] count,
  output logic             tc
);

  logic [CYC_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + CYC_W'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == load);

endmodule

// File: rtl/mcy_mutant_scheduler.sv
// Steps mutsel through mutants 1..N, runs an observation window per mutant and
// streams one kill record each. Optional macro: MCY_SCHED_EARLY_KILL_EN.
module mcy_mutant_scheduler
  import mcy_sched_pkg::*;
#(
  parameter int MUTSEL_W   = 8,
  parameter int RST_CYCLES = 4,
  parameter int CYC_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [MUTSEL_W-1:0] num_mutants_i,
  input  logic [CYC_W-1:0]    run_cycles_i,
  input  logic                mismatch_i,
  output logic [MUTSEL_W-1:0] mutsel_o,
  output logic                core_rst_no,
  output logic                fetch_enable_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [MUTSEL_W-1:0] res_mutsel_o,
  output logic                res_killed_o,
  output logic [CYC_W-1:0]    res_cycle_o
);

  localparam int RST_EFF = (RST_CYCLES < RST_CYCLES_MIN) ? RST_CYCLES_MIN : RST_CYCLES;
  localparam logic [CYC_W-1:0] RST_LOAD = CYC_W'(RST_EFF - 1);

  sched_state_e        state_reg;
  logic [MUTSEL_W-1:0] mutsel_reg, num_reg, res_mutsel_reg;
  logic [CYC_W-1:0]    run_reg, cycle_reg;
  logic                killed_reg, core_rst_n_reg, fetch_reg, busy_reg, done_reg, valid_reg;

  logic                tmr_clear, tmr_enable, tmr_tc;
  logic [CYC_W-1:0]    tmr_load, tmr_count;
  logic                kill_now, run_end;

  // Terminal counts are "last cycle" indices, hence the minus one.
  assign tmr_enable = (state_reg == CRST) || (state_reg == RUN);
  assign tmr_clear  = !tmr_enable || ((state_reg == CRST) && tmr_tc);
  assign tmr_load   = (state_reg == CRST) ? RST_LOAD : run_reg - CYC_W'(1);

  mcy_sched_timer #(.CYC_W(CYC_W)) u_timer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .load   (tmr_load),
    .count  (tmr_count),
    .tc     (tmr_tc)
  );

  assign kill_now = (state_reg == RUN) && mismatch_i && !killed_reg;

`ifdef MCY_SCHED_EARLY_KILL_EN
  assign run_end = tmr_tc || kill_now;
`else
  assign run_end = tmr_tc;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      mutsel_reg     <= '0;
      num_reg        <= '0;
      run_reg        <= '0;
      res_mutsel_reg <= '0;
      cycle_reg      <= '0;
      killed_reg     <= 1'b0;
      core_rst_n_reg <= 1'b0;
      fetch_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if ((num_mutants_i == '0) || (run_cycles_i == '0)) begin
              done_reg <= 1'b1;
            end else begin
              num_reg    <= num_mutants_i;
              run_reg    <= run_cycles_i;
              mutsel_reg <= MUTSEL_W'(1);
              killed_reg <= 1'b0;
              cycle_reg  <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= CRST;
            end
          end
        end
        CRST: begin
          if (tmr_tc) begin
            core_rst_n_reg <= 1'b1;
            fetch_reg      <= 1'b1;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          if (kill_now) begin
            killed_reg <= 1'b1;
            cycle_reg  <= tmr_count;
          end
          if (run_end) begin
            core_rst_n_reg <= 1'b0;
            fetch_reg      <= 1'b0;
            valid_reg      <= 1'b1;
            res_mutsel_reg <= mutsel_reg;
            state_reg      <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          // Compare before increment so the all-ones mutant never wraps to 0.
          if (mutsel_reg == num_reg) begin
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            mutsel_reg <= '0;
            state_reg  <= IDLE;
          end else begin
            mutsel_reg <= mutsel_reg + MUTSEL_W'(1);
            killed_reg <= 1'b0;
            cycle_reg  <= '0;
            state_reg  <= CRST;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mutsel_o       = mutsel_reg;
  assign core_rst_no    = core_rst_n_reg;
  assign fetch_enable_o = fetch_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign res_valid_o    = valid_reg;
  assign res_mutsel_o   = res_mutsel_reg;
  assign res_killed_o   = killed_reg;
  assign res_cycle_o    = cycle_reg;

endmodule
